// File: rtl/hough_vote_ctrl_pkg.sv
// Shared definitions for the Hough transform vote controller: FSM encoding,
// coordinate width and the default theta sweep length.
package hough_vote_ctrl_pkg;

  localparam int COORD_W         = 8;
  localparam int THETA_STEPS_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_VOTE = 2'd2,
    ST_DONE = 2'd3
  } hv_state_e;

endpackage

// File: rtl/hough_coord_track.sv
// Tracks the raster position of accepted pixel beats and captures the length
// of each completed row.
module hough_coord_track
  import hough_vote_ctrl_pkg::*;
(
  input  logic               Clk,
  input  logic               nReset,
  input  logic               accept,
  input  logic               Line,
  input  logic               clear,
  output logic [COORD_W-1:0] column,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] Width
);

  logic [COORD_W-1:0] column_q, column_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] width_q, width_d;

  // Width deliberately ignores clear so it survives from one frame to the next.
  always_comb begin
    column_d = column_q;
    row_d    = row_q;
    width_d  = width_q;
    if (clear) begin
      column_d = '0;
      row_d    = '0;
    end else if (accept) begin
      if (Line) begin
        column_d = '0;
        row_d    = row_q + COORD_W'(1);
        width_d  = column_q + COORD_W'(1);
      end else begin
        column_d = column_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      column_q <= '0;
      row_q    <= '0;
      width_q  <= '0;
    end else begin
      column_q <= column_d;
      row_q    <= row_d;
      width_q  <= width_d;
    end
  end

  assign column = column_q;
  assign row    = row_q;
  assign Width  = width_q;

endmodule

// File: rtl/hough_vote_ctrl.sv
// Hough vote controller: scans a pixel stream and, for every edge pixel,
// issues THETA_STEPS votes (one per theta bin) to an accumulator.
module hough_vote_ctrl
  import hough_vote_ctrl_pkg::*;
#(
  parameter int THETA_STEPS = THETA_STEPS_DEF,
  parameter int TW          = 5
) (
  input  logic               nReset,
  input  logic               Clk,
  input  logic               Start,
  input  logic               PixelValid,
  output logic               PixelReady,
  input  logic               Edge,
  input  logic               Line,
  input  logic               Last,
  output logic               VoteValid,
  input  logic               VoteReady,
  output logic [COORD_W-1:0] VoteX,
  output logic [COORD_W-1:0] VoteY,
  output logic [TW-1:0]      Theta,
  output logic [COORD_W-1:0] Width,
  output logic               Busy,
  output logic               FrameDone
);

  localparam logic [TW-1:0] THETA_LAST = TW'(THETA_STEPS - 1);

  hv_state_e          state_q, state_d;
  logic [COORD_W-1:0] vote_x_q, vote_x_d;
  logic [COORD_W-1:0] vote_y_q, vote_y_d;
  logic [TW-1:0]      theta_q, theta_d;
  logic               pend_last_q, pend_last_d;
  logic               frame_done_q, frame_done_d;

  logic               accept;
  logic               clear;
  logic [COORD_W-1:0] column;
  logic [COORD_W-1:0] row;

  assign accept = (state_q == ST_SCAN) && PixelValid;
  assign clear  = (state_q == ST_IDLE) && Start;

  hough_coord_track u_coord (
    .Clk    (Clk),
    .nReset (nReset),
    .accept (accept),
    .Line   (Line),
    .clear  (clear),
    .column (column),
    .row    (row),
    .Width  (Width)
  );

  // An edge on the frame's final beat still gets its full vote sweep; the
  // pending-last flag remembers to finish the frame once the sweep ends.
  always_comb begin
    state_d      = state_q;
    vote_x_d     = vote_x_q;
    vote_y_d     = vote_y_q;
    theta_d      = theta_q;
    pend_last_d  = pend_last_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (accept) begin
          if (Edge) begin
            vote_x_d    = column;
            vote_y_d    = row;
            theta_d     = '0;
            pend_last_d = Last;
            state_d     = ST_VOTE;
          end else if (Last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_VOTE: begin
        if (VoteReady) begin
          if (theta_q != THETA_LAST) begin
            theta_d = theta_q + TW'(1);
          end else begin
            state_d = pend_last_q ? ST_DONE : ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        pend_last_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    frame_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= ST_IDLE;
      vote_x_q     <= '0;
      vote_y_q     <= '0;
      theta_q      <= '0;
      pend_last_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vote_x_q     <= vote_x_d;
      vote_y_q     <= vote_y_d;
      theta_q      <= theta_d;
      pend_last_q  <= pend_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign PixelReady = (state_q == ST_SCAN);
  assign VoteValid  = (state_q == ST_VOTE);
  assign Busy       = (state_q != ST_IDLE);
  assign FrameDone  = frame_done_q;
  assign VoteX      = vote_x_q;
  assign VoteY      = vote_y_q;
  assign Theta      = theta_q;

endmodule
